// File: rtl/zero_in_channel_pkg.sv
// Shared definitions for the Zero input channel.
//   MemoryElementWidth : default channel word width (matches runner memory elements)
//   zero_word_t        : one channel word at the default width
//   zero_count_width   : bits needed to hold an occupancy count of 0..n
//   zero_index_width   : bits needed to hold a ring index of 0..n-1 (at least 1)
package zero_in_channel_pkg;

  localparam int unsigned MemoryElementWidth = 12;

  typedef logic [MemoryElementWidth-1:0] zero_word_t;

  function automatic int unsigned zero_count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned zero_index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zero_in_channel_ring_index.sv
// Ring index counter: steps 0, 1, ..., N-1, 0, ... on each cycle where advance is high.
// The wrap is an explicit compare, so N need not be a power of two.
// Ports:
//   clock   : clock, all updates on posedge
//   reset   : synchronous active-high, returns idx to 0
//   advance : step the index this cycle
//   idx     : current index (registered)
module zero_ring_index
  import zero_in_channel_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           advance,
  output logic [zero_index_width(N)-1:0] idx
);

  localparam int unsigned IW = zero_index_width(N);

  logic [IW-1:0] idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q <= '0;
    end else if (advance) begin
      idx_q <= (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/zero_in_channel.sv
// Input channel for the Zero program runner. A loader pushes words into an NIn-deep FIFO; the
// core's `in` instruction pops the oldest word and `inSize` reads the remaining count.
// Optional feature macro: ZERO_IN_UNDERFLOW_EN adds a sticky underflow flag.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   loadValid    : loader offers loadData this cycle
//   loadData     : word to append
//   loadReady    : channel can accept a word (not full)
//   inRequest    : pop one word
//   inData       : popped word, registered, holds its value on an empty pop
//   inValid      : one-cycle pulse after a successful pop
//   inSize       : words remaining (registered count)
//   empty        : inSize == 0
//   underflow    : sticky, set by a pop attempt while empty (ZERO_IN_UNDERFLOW_EN only)
module zero_in_channel #(
  parameter int unsigned MemoryElementWidth = zero_in_channel_pkg::MemoryElementWidth,
  parameter int unsigned NIn                = 3
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic                                               loadValid,
  input  logic [MemoryElementWidth-1:0]                      loadData,
  output logic                                               loadReady,
  input  logic                                               inRequest,
  output logic [MemoryElementWidth-1:0]                      inData,
  output logic                                               inValid,
  output logic [zero_in_channel_pkg::zero_count_width(NIn)-1:0] inSize,
  output logic                                               empty
`ifdef ZERO_IN_UNDERFLOW_EN
  ,
  output logic                                               underflow
`endif
);

  import zero_in_channel_pkg::*;

  localparam int unsigned CW = zero_count_width(NIn);
  localparam int unsigned IW = zero_index_width(NIn);

  logic [MemoryElementWidth-1:0] mem [NIn];
  logic [IW-1:0]                 rd_idx;
  logic [IW-1:0]                 wr_idx;
  logic [CW-1:0]                 count_q;
  logic [MemoryElementWidth-1:0] data_q;
  logic                          valid_q;
  logic                          push;
  logic                          pop;

  // Both handshakes look only at the registered count, so a full channel refuses a push even
  // when a pop frees a slot in the same cycle, and a push into an empty channel cannot be
  // popped until the next cycle.
  assign loadReady = (count_q != CW'(NIn));
  assign empty     = (count_q == '0);
  assign push      = loadValid && loadReady;
  assign pop       = inRequest && !empty;

  zero_ring_index #(
    .N (NIn)
  ) u_rd_ptr (
    .clock   (clock),
    .reset   (reset),
    .advance (pop),
    .idx     (rd_idx)
  );

  zero_ring_index #(
    .N (NIn)
  ) u_wr_ptr (
    .clock   (clock),
    .reset   (reset),
    .advance (push),
    .idx     (wr_idx)
  );

  // Storage is not reset; stale words are unreachable once the pointers and count clear.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_idx] <= loadData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop;
      if (pop) begin
        data_q <= mem[rd_idx];
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ZERO_IN_UNDERFLOW_EN
  logic underflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_q <= 1'b0;
    end else if (inRequest && empty) begin
      underflow_q <= 1'b1;
    end
  end

  assign underflow = underflow_q;
`endif

  assign inData  = data_q;
  assign inValid = valid_q;
  assign inSize  = count_q;

endmodule

// File: tb/tb_zero_in_channel.sv
// Self-checking bench for zero_in_channel: directed scenarios followed by randomized traffic,
// all compared against a queue-based reference model of the channel.
module tb_zero_in_channel;

  localparam int unsigned W  = 12;
  localparam int unsigned N  = 3;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          loadValid;
  logic [W-1:0]  loadData;
  logic          loadReady;
  logic          inRequest;
  logic [W-1:0]  inData;
  logic          inValid;
  logic [CW-1:0] inSize;
  logic          empty;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int unsigned q[$];
  int unsigned m_data  = 0;
  bit          m_valid = 0;
  bit          m_uf    = 0;

  always #5 clock = ~clock;

  zero_in_channel #(
    .MemoryElementWidth (W),
    .NIn                (N)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .loadValid (loadValid),
    .loadData  (loadData),
    .loadReady (loadReady),
    .inRequest (inRequest),
    .inData    (inData),
    .inValid   (inValid),
    .inSize    (inSize),
    .empty     (empty)
`ifdef ZERO_IN_UNDERFLOW_EN
    ,
    .underflow (underflow)
`endif
  );

`ifndef ZERO_IN_UNDERFLOW_EN
  assign underflow = 1'b0;
`endif

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("inData", 32'(inData), m_data);
    check("inValid", 32'(inValid), 32'(m_valid));
    check("inSize", 32'(inSize), q.size());
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("loadReady", 32'(loadReady), 32'(q.size() < N));
`ifdef ZERO_IN_UNDERFLOW_EN
    check("underflow", 32'(underflow), 32'(m_uf));
`endif
  endtask

  // Drive one cycle's inputs, clock it, advance the model, then compare everything.
  task automatic cyc(input bit lv, input int unsigned ld, input bit ir, input bit rst);
    bit do_push;
    bit do_pop;
    reset     = rst;
    loadValid = lv;
    loadData  = W'(ld);
    inRequest = ir;
    do_push   = lv && (q.size() < N);
    do_pop    = ir && (q.size() > 0);
    @(posedge clock);
    #1;
    if (rst) begin
      q.delete();
      m_data  = 0;
      m_valid = 0;
      m_uf    = 0;
    end else begin
      if (ir && !do_pop) m_uf = 1;
      m_valid = do_pop;
      if (do_pop) m_data = q.pop_front();
      if (do_push) q.push_back(ld % (1 << W));
    end
    check_all();
  endtask

  initial begin
    reset     = 1'b1;
    loadValid = 1'b0;
    loadData  = '0;
    inRequest = 1'b0;

    // Reset state.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("rst_inSize", 32'(inSize), 0);
    check("rst_loadReady", 32'(loadReady), 1);
    check("rst_inData", 32'(inData), 0);

    // 1: fill to capacity, extra load ignored.
    cyc(1, 33, 0, 0); check("t1_size1", 32'(inSize), 1);
    cyc(1, 22, 0, 0); check("t1_size2", 32'(inSize), 2);
    cyc(1, 11, 0, 0); check("t1_size3", 32'(inSize), 3);
    check("t1_full_ready", 32'(loadReady), 0);
    cyc(1, 44, 0, 0); check("t1_overflow_size", 32'(inSize), 3);

    // 2: drain in order.
    cyc(0, 0, 1, 0); check("t2_pop33", 32'(inData), 33); check("t2_v1", 32'(inValid), 1);
    cyc(0, 0, 1, 0); check("t2_pop22", 32'(inData), 22);
    cyc(0, 0, 1, 0); check("t2_pop11", 32'(inData), 11);
    check("t2_empty", 32'(empty), 1);

    // 3: pop while empty.
    cyc(0, 0, 1, 0); check("t3_hold", 32'(inData), 11); check("t3_nov", 32'(inValid), 0);
`ifdef ZERO_IN_UNDERFLOW_EN
    check("t3_uf", 32'(underflow), 1);
    cyc(0, 0, 0, 0); check("t3_uf_sticky", 32'(underflow), 1);
`endif

    // 4: pointer wrap.
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0);
    cyc(0, 0, 1, 0); check("t4_pop1", 32'(inData), 1);
    cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
    cyc(0, 0, 1, 0); check("t4_pop2", 32'(inData), 2);
    cyc(0, 0, 1, 0); check("t4_pop3", 32'(inData), 3);
    cyc(0, 0, 1, 0); check("t4_pop4", 32'(inData), 4);
    check("t4_size0", 32'(inSize), 0);

    // 5: simultaneous push and pop.
    cyc(1, 5, 0, 0); cyc(1, 6, 0, 0);
    cyc(1, 7, 1, 0); check("t5_pop5", 32'(inData), 5); check("t5_size", 32'(inSize), 2);
    cyc(0, 0, 1, 0); check("t5_pop6", 32'(inData), 6);
    cyc(0, 0, 1, 0); check("t5_pop7", 32'(inData), 7);

    // Push into empty with a same-cycle pop: word retained, no pop.
    cyc(1, 9, 1, 0); check("push_empty_pop_v", 32'(inValid), 0);
    check("push_empty_pop_size", 32'(inSize), 1);
    cyc(0, 0, 1, 0); check("push_empty_pop_data", 32'(inData), 9);

    // 6: reset mid-operation with a pop request.
    cyc(1, 8, 0, 0); cyc(1, 10, 0, 0);
    cyc(0, 0, 1, 1);
    check("t6_size", 32'(inSize), 0); check("t6_v", 32'(inValid), 0);
    check("t6_data", 32'(inData), 0); check("t6_ready", 32'(loadReady), 1);
    cyc(0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(bit'($urandom_range(0, 1)), $urandom_range(0, (1 << W) - 1),
          bit'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
